// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types.
//   NumDigits : BCD significand digit count
//   ExpW      : exponent field width (holds 0..2*NumDigits-1)
//   num_t     : {error, sign, significand (BCD, digit NumDigits-1 in the MS nibble), exponent}
package calc_pkg;

  parameter int unsigned NumDigits = 8;
  parameter int unsigned ExpW      = $clog2(NumDigits) + 1;

  typedef struct packed {
    logic                   error;
    logic                   sign;
    logic [4*NumDigits-1:0] significand;
    logic [ExpW-1:0]        exponent;
  } num_t;

endpackage

// File: rtl/num_tokenizer.sv
// num_tokenizer: serializes one calc_pkg::num_t into 4-bit display tokens, MS first.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   num_i, in_valid_i       : number in; accepted when in_ready_o is high
//   in_ready_o              : idle, can accept a number
//   tok_o, tok_last_o       : token (0-9 digit, A '.', B '-', E error) and last flag
//   out_valid_o, out_ready_i: token handshake
// Optional build macro TRAILING_ZERO_TRIM_EN: drop trailing fractional zeros (and a
// bare '.'); a zero significand renders as a single '0'.
module num_tokenizer #(
  parameter int unsigned NumDigits = calc_pkg::NumDigits
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  calc_pkg::num_t  num_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic [3:0]      tok_o,
  output logic            tok_last_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);

  localparam int unsigned DigW = $clog2(NumDigits) + 1;
  localparam int unsigned ExpW = calc_pkg::ExpW;

  localparam logic [3:0] TokPoint = 4'hA;
  localparam logic [3:0] TokMinus = 4'hB;
  localparam logic [3:0] TokErr   = 4'hE;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [4*NumDigits-1:0] sig_q, sig_d;
  logic                   minus_q, minus_d;     // '-' still to be emitted
  logic                   pt_now_q, pt_now_d;   // '.' is the next token
  logic                   has_pt_q, has_pt_d;
  logic [DigW-1:0]        pt_idx_q, pt_idx_d;   // digit index the '.' follows
  logic [DigW-1:0]        last_idx_q, last_idx_d;
  logic [DigW-1:0]        dig_q, dig_d;         // index of the next digit
  logic [3:0]             tok_q, tok_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;

  // Plan derived from num_i at acceptance
  logic            acc_err, acc_minus, acc_has_pt;
  logic [DigW-1:0] acc_pt_idx, acc_last_idx;
`ifdef TRAILING_ZERO_TRIM_EN
  logic [DigW-1:0] lz;
`endif

  // Cursor fed to the token step: fresh plan when idle, registered cursor when emitting
  logic [4*NumDigits-1:0] cur_sig;
  logic                   cur_minus, cur_pt_now, cur_has_pt;
  logic [DigW-1:0]        cur_pt_idx, cur_last_idx, cur_dig;
  logic [3:0]             cur_digit;

  logic [3:0]      nxt_tok;
  logic            nxt_last, nxt_minus, nxt_pt_now;
  logic [DigW-1:0] nxt_dig;

  always_comb begin
    acc_err      = num_i.error || (num_i.exponent > ExpW'(NumDigits - 1));
    acc_minus    = num_i.sign && (num_i.significand != '0);
    acc_has_pt   = num_i.exponent < ExpW'(NumDigits - 1);
    acc_pt_idx   = acc_has_pt ? DigW'(NumDigits - 1) - DigW'(num_i.exponent) : '0;
    acc_last_idx = '0;
`ifdef TRAILING_ZERO_TRIM_EN
    // Lowest nonzero digit bounds the trim; integer digits always survive
    lz = '0;
    for (int i = int'(NumDigits) - 1; i >= 0; i--) begin
      if (num_i.significand[4*i +: 4] != 4'h0) lz = DigW'(i);
    end
    if (num_i.significand == '0) begin
      acc_last_idx = DigW'(NumDigits - 1);
      acc_has_pt   = 1'b0;
    end else if (acc_has_pt) begin
      if (lz < acc_pt_idx) begin
        acc_last_idx = lz;
      end else begin
        acc_last_idx = acc_pt_idx;
        acc_has_pt   = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    if (state_q == StIdle) begin
      cur_sig      = num_i.significand;
      cur_minus    = acc_minus;
      cur_pt_now   = 1'b0;
      cur_has_pt   = acc_has_pt;
      cur_pt_idx   = acc_pt_idx;
      cur_last_idx = acc_last_idx;
      cur_dig      = DigW'(NumDigits - 1);
    end else begin
      cur_sig      = sig_q;
      cur_minus    = minus_q;
      cur_pt_now   = pt_now_q;
      cur_has_pt   = has_pt_q;
      cur_pt_idx   = pt_idx_q;
      cur_last_idx = last_idx_q;
      cur_dig      = dig_q;
    end

    cur_digit = 4'h0;
    for (int i = 0; i < int'(NumDigits); i++) begin
      if (cur_dig == DigW'(i)) cur_digit = cur_sig[4*i +: 4];
    end

    // One step of the token walk: '-', then digits with '.' spliced in
    nxt_tok    = cur_digit;
    nxt_last   = 1'b0;
    nxt_minus  = cur_minus;
    nxt_pt_now = cur_pt_now;
    nxt_dig    = cur_dig;
    if (cur_minus) begin
      nxt_tok   = TokMinus;
      nxt_minus = 1'b0;
    end else if (cur_pt_now) begin
      nxt_tok    = TokPoint;
      nxt_pt_now = 1'b0;
    end else begin
      nxt_last   = (cur_dig == cur_last_idx);
      nxt_pt_now = cur_has_pt && (cur_dig == cur_pt_idx);
      nxt_dig    = (cur_dig == '0) ? '0 : cur_dig - DigW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    minus_d    = minus_q;
    pt_now_d   = pt_now_q;
    has_pt_d   = has_pt_q;
    pt_idx_d   = pt_idx_q;
    last_idx_d = last_idx_q;
    dig_d      = dig_q;
    tok_d      = tok_q;
    last_d     = last_q;
    valid_d    = valid_q;
    ready_d    = ready_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          sig_d      = num_i.significand;
          has_pt_d   = acc_has_pt;
          pt_idx_d   = acc_pt_idx;
          last_idx_d = acc_last_idx;
          valid_d    = 1'b1;
          ready_d    = 1'b0;
          state_d    = StEmit;
          if (acc_err) begin
            tok_d  = TokErr;
            last_d = 1'b1;
          end else begin
            tok_d    = nxt_tok;
            last_d   = nxt_last;
            minus_d  = nxt_minus;
            pt_now_d = nxt_pt_now;
            dig_d    = nxt_dig;
          end
        end
      end
      StEmit: begin
        if (valid_q && out_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            tok_d    = nxt_tok;
            last_d   = nxt_last;
            minus_d  = nxt_minus;
            pt_now_d = nxt_pt_now;
            dig_d    = nxt_dig;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sig_q      <= '0;
      minus_q    <= 1'b0;
      pt_now_q   <= 1'b0;
      has_pt_q   <= 1'b0;
      pt_idx_q   <= '0;
      last_idx_q <= '0;
      dig_q      <= '0;
      tok_q      <= 4'h0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      minus_q    <= minus_d;
      pt_now_q   <= pt_now_d;
      has_pt_q   <= has_pt_d;
      pt_idx_q   <= pt_idx_d;
      last_idx_q <= last_idx_d;
      dig_q      <= dig_d;
      tok_q      <= tok_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign tok_o       = tok_q;
  assign tok_last_o  = last_q;
  assign out_valid_o = valid_q;

endmodule

// File: doc/num_tokenizer.md
Name: num_tokenizer

Overview:
- Consumer at the far end of an ALU result handshake.
- Accepts one calc_pkg::num_t with valid/ready and serializes it into a stream of 4-bit display tokens, most significant first, one token per cycle, with valid/ready and a last flag.
- Sits between the ALU result mux and the display/scan-out logic.

Parameters:
NumDigits, calc_pkg::NumDigits, number of BCD significand digits; must match calc_pkg.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
num_i  input  calc_pkg::num_t  number to render (sign, significand, exponent, error)
in_valid_i  input  1  num_i valid
in_ready_o  output  1  block idle, can accept a number
tok_o  output  4  token: 0-9 digit, 4'hA '.', 4'hB '-', 4'hE 'E' (error/overflow)
tok_last_o  output  1  final token of the current number
out_valid_o  output  1  tok_o/tok_last_o valid
out_ready_i  input  1  downstream accepts token

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: in_ready_o=1, out_valid_o=0, tok_o=0, tok_last_o=0, state S_IDLE.
- Reset mid-stream aborts the number; no further tokens are emitted.
- All outputs are registered.
- States and transitions:
  - S_IDLE: in_ready_o=1. On in_valid_i: latch num_i, in_ready_o goes 0 next cycle, go to S_EMIT.
  - S_EMIT: walks the token sequence. The first token is valid the cycle after acceptance.
  - In S_EMIT, the token advances only on out_valid_o && out_ready_i. tok_o and tok_last_o stay stable while out_valid_o && !out_ready_i.
  - Throughput: one token per cycle with out_ready_i held high.
  - After the handshake of the token with tok_last_o=1: out_valid_o=0 and in_ready_o=1 on the next cycle, back to S_IDLE.
  - Back-to-back numbers: one idle bubble between last token and next first token.
- Token sequence, first match wins:
  1. error=1 -> single token 'E', last.
  2. exponent > NumDigits-1 -> single token 'E', last (overflow).
  3. Otherwise:
     - '-' only if sign=1 and significand!=0; negative zero renders unsigned.
     - Then all NumDigits digits, index NumDigits-1 down to 0.
     - '.' is inserted immediately after digit index NumDigits-1-exponent when exponent < NumDigits-1.
     - No point when exponent == NumDigits-1.
     - The last digit carries tok_last_o.
- Token count (case 3): NumDigits + (minus ? 1 : 0) + (point ? 1 : 0).
- Digit counter: $clog2(NumDigits)+1 bits, counting down, no wrap past 0.
- in_valid_i while busy is ignored; the input is not latched.
- The latched number is immune to num_i changes after acceptance.

Optional Feature:
TRAILING_ZERO_TRIM_EN
- Defined:
  - Fractional digits (after the '.') that are zero and follow the last nonzero fractional digit are not emitted.
  - If all fractional digits are zero, the '.' is also omitted; the units digit becomes last.
  - Trim position is computed once at acceptance from the latched significand.
  - Integer digits are never trimmed.
  - Significand == 0 renders as single '0', last.
- Undefined: full sequence per Behaviour; no trimming logic is synthesized.

Test Plan:
All cases use NumDigits=8, out_ready_i=1 unless stated.
1. sign=1, significand=12345000, exponent=2 -> '-','1','2','3','.','4','5','0','0','0' with last on the final '0'; first token 1 cycle after accept; in_ready_o=1 one cycle after the last handshake.
2. error=1 (any other fields), and separately exponent=9 -> single 'E' with tok_last_o=1; 2 cycles from accept to in_ready_o=1.
3. sign=1, significand=0, exponent=0 -> '0','.','0'x7; no '-' token; last on the 9th token.
4. significand=98765432, exponent=7 -> 8 digit tokens, no point. Toggle out_ready_i low for 3 cycles mid-stream -> tok_o held constant, no token lost or duplicated. Pulse in_valid_i during the stream -> ignored.
5. Assert rst_i while token 4 is valid -> next cycle out_valid_o=0, in_ready_o=1; a following number renders correctly from its first token.
6. With TRAILING_ZERO_TRIM_EN: 12345000, exp=2 -> '1','2','3','.','4','5' (last on '5'). 50000000, exp=0 -> '5' (last). Without the macro -> the full 9-token sequence.
